// File: rtl/imem_loader.sv
// Program loader: turns a framed little-endian byte stream into sequential
// 32-bit instruction-memory writes, verifies an 8-bit checksum and holds the core meanwhile.
module imem_loader #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          err,
  output logic [AW:0]   words_written
);

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    WRITE,
    CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state;
  logic [7:0]    len_lo;
  logic [AW:0]   len;
  logic [7:0]    sum;
  logic [1:0]    idx;
  logic [31:0]   word;
  logic [AW-1:0] addr;

  logic          accept;
  logic [15:0]   len_full;
  logic [7:0]    sum_next;
  logic [31:0]   word_next;
  logic [AW:0]   ww_inc;
  logic          start_ok;

  assign accept   = in_valid && in_ready;
  assign len_full = {in_data, len_lo};
  assign sum_next = sum + in_data;
  assign ww_inc   = words_written + (AW+1)'(1);
  assign start_ok = start && ((state == IDLE) || (state == S_DONE) || (state == S_ERR));

  always_comb begin
    word_next = word;
    word_next[{idx, 3'b000} +: 8] = in_data;
  end

  // in_ready is registered: every transition loads the ready level of the state it enters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      in_ready      <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      cpu_hold      <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      words_written <= '0;
      len_lo        <= '0;
      len           <= '0;
      sum           <= '0;
      idx           <= '0;
      word          <= '0;
      addr          <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start_ok) begin
        done          <= 1'b0;
        err           <= 1'b0;
        sum           <= '0;
        idx           <= '0;
        words_written <= '0;
        addr          <= '0;
        cpu_hold      <= 1'b1;
        in_ready      <= 1'b1;
        state         <= LEN0;
      end else begin
        unique case (state)
          LEN0: begin
            if (accept) begin
              len_lo <= in_data;
              sum    <= sum_next;
              state  <= LEN1;
            end
          end
          LEN1: begin
            if (accept) begin
              sum <= sum_next;
              len <= len_full[AW:0];
              if (len_full > 16'(DEPTH)) begin
                err      <= 1'b1;
                in_ready <= 1'b0;
                state    <= S_ERR;
              end else if (len_full == '0) begin
                state <= CSUM;
              end else begin
                state <= DATA;
              end
            end
          end
          DATA: begin
            if (accept) begin
              sum  <= sum_next;
              word <= word_next;
              idx  <= idx + 2'd1;
              if (idx == 2'd3) begin
                mem_we    <= 1'b1;
                mem_addr  <= addr;
                mem_wdata <= word_next;
                in_ready  <= 1'b0;
                state     <= WRITE;
              end
            end
          end
          WRITE: begin
            words_written <= ww_inc;
            in_ready      <= 1'b1;
            // The address saturates on the final word so it cannot wrap before CSUM.
            if (ww_inc == len) begin
              state <= CSUM;
            end else begin
              addr  <= addr + AW'(1);
              state <= DATA;
            end
          end
          CSUM: begin
            if (accept) begin
              sum      <= sum_next;
              in_ready <= 1'b0;
              if (sum_next == '0) begin
                done     <= 1'b1;
                cpu_hold <= 1'b0;
                state    <= S_DONE;
              end else begin
                err   <= 1'b1;
                state <= S_ERR;
              end
            end
          end
          default: begin
            in_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of frame cases plus hand-written overflow and
// mid-load reset sequences; memory writes are checked against a scoreboard queue.
module tb_imem_loader;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          err;
  logic [AW:0]   words_written;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err), .words_written(words_written)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    int unsigned n;
    bit          fixed;
    bit          gaps;
    logic [7:0]  delta;
    bit          exp_done;
    bit          exp_err;
  } case_t;

  wr_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with no write expected",
                 mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("write_addr", 32'(mem_addr), 32'(e.addr));
        check("write_data", mem_wdata, e.data);
      end
    end
  end

  // Entered and left at a negedge; returns once the byte has been accepted.
  task automatic send(input logic [7:0] b, input bit gaps);
    bit acc;
    in_data = b;
    for (int unsigned c = 0; c < 200; c++) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      acc = in_valid && in_ready;
      @(posedge clk);
      @(negedge clk);
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    n_fail++;
    $display("FAIL byte_timeout: byte 0x%0h not accepted within 200 cycles", b);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("start_cpu_hold", 32'(cpu_hold), 32'd1);
    check("start_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic run_frame(input case_t tc, input int unsigned id);
    logic [31:0] w[$];
    logic [7:0]  fb[$];
    logic [7:0]  s;
    string       tag;
    tag = $sformatf("case%0d", id);
    for (int unsigned i = 0; i < tc.n; i++) begin
      if (tc.fixed && i == 0) w.push_back(32'h0000_0293);
      else if (tc.fixed && i == 1) w.push_back(32'h0010_0313);
      else w.push_back($urandom());
    end
    fb.push_back(8'(tc.n));
    fb.push_back(8'(tc.n >> 8));
    foreach (w[i]) for (int unsigned k = 0; k < 4; k++) fb.push_back(w[i][8*k +: 8]);
    s = '0;
    foreach (fb[i]) s = s + fb[i];
    fb.push_back(8'(8'h00 - s) + tc.delta);
    do_start();
    foreach (fb[k]) begin
      if (k >= 2 && k < 2 + 4 * int'(tc.n) && (k - 2) % 4 == 3) begin
        wr_t e;
        e.addr = AW'((k - 2) / 4);
        e.data = w[(k - 2) / 4];
        sb.push_back(e);
      end
      send(fb[k], tc.gaps);
    end
    check({tag, "_done"}, 32'(done), 32'(tc.exp_done));
    check({tag, "_err"}, 32'(err), 32'(tc.exp_err));
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!tc.exp_done));
    check({tag, "_words"}, 32'(words_written), tc.n);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_pending"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_words"}, 32'(words_written), 32'd0);
  endtask

  initial begin
    case_t cases[6];
    cases[0] = '{n: 2,  fixed: 1, gaps: 0, delta: 8'h00, exp_done: 1, exp_err: 0};
    cases[1] = '{n: 2,  fixed: 1, gaps: 0, delta: 8'h01, exp_done: 0, exp_err: 1};
    cases[2] = '{n: 2,  fixed: 1, gaps: 1, delta: 8'h00, exp_done: 1, exp_err: 0};
    cases[3] = '{n: 0,  fixed: 0, gaps: 0, delta: 8'h00, exp_done: 1, exp_err: 0};
    cases[4] = '{n: 64, fixed: 0, gaps: 0, delta: 8'h00, exp_done: 1, exp_err: 0};
    cases[5] = '{n: 5,  fixed: 0, gaps: 1, delta: 8'h80, exp_done: 0, exp_err: 1};

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int unsigned i = 0; i < 6; i++) run_frame(cases[i], i);

    // Length overflow: ERR right after LEN_HI, no writes, bytes refused.
    do_start();
    send(8'h41, 1'b0);
    send(8'h00, 1'b0);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_done", 32'(done), 32'd0);
    check("ovf_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_data = 8'h55;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    check("ovf_in_ready_later", 32'(in_ready), 32'd0);
    check("ovf_words", 32'(words_written), 32'd0);
    check("ovf_cpu_hold", 32'(cpu_hold), 32'd1);

    // Reset after two data bytes of word 0: nothing written, outputs back to reset.
    do_start();
    send(8'h01, 1'b0);
    send(8'h00, 1'b0);
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_mem_we", 32'(mem_we), 32'd0);
    run_frame(cases[0], 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
